decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised MIPS instruction-decode stage with an ID/EX output register, valid/ready handshake, flush, and a write-back port. It splits the fetched instruction into fields and reads both source operands from an internal register file, with same-cycle write-back bypass. Immediates are sign- or zero-extended. It sits between the fetch stage and execute, and receives write-back from the final stage.

## Interface
- DATA_W, 32, register/operand width
- REG_ADDR_W, 5, register index width; register count = 2**REG_ADDR_W
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction present on `instr`
- in_ready  out  1  stage accepts instruction this cycle
- instr  in  32  fetched instruction
- reg_dst  in  1  destination select: 1 = rd, 0 = rt
- reg_write  in  1  instruction writes a register
- zero_ext  in  1  1 = zero-extend immediate, 0 = sign-extend
- flush  in  1  discard held and incoming instruction
- wb_en  in  1  write-back enable
- wb_addr  in  REG_ADDR_W  write-back register index
- wb_data  in  DATA_W  write-back data
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  execute stage consumes held instruction
- out_rs_data, out_rt_data  out  DATA_W  operand values
- out_imm  out  DATA_W  extended immediate
- out_rs, out_rt, out_dest  out  REG_ADDR_W  source and destination indices
- out_opcode, out_funct  out  6  opcode and function fields
- out_shamt  out  5  shift amount
- out_addr  out  26  jump target field
- out_reg_write  out  1  registered copy of reg_write

## Operation
- Field split: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], addr[25:0]. rs/rt/rd are the low REG_ADDR_W bits of their fields.
- Destination: out_dest = reg_dst ? rd : rt.
- Immediate: zero_ext ? {0, imm} : {DATA_W-16 copies of imm[15], imm}.
- Register file: written on the clock edge when wb_en is high, except index 0 when ZERO_REG=1.
- Register file reads are combinational with bypass. If wb_en is high and wb_addr equals the read index (and the index is not 0 with ZERO_REG), the read returns wb_data.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept = in_valid && in_ready. Accept loads all out_* fields and sets out_valid.
  - Consume without accept clears out_valid.
- Stall refresh: while out_valid && !out_ready, a write-back whose index matches held out_rs (nonzero, or any index if ZERO_REG=0) updates out_rs_data with wb_data. The same rule applies to out_rt and out_rt_data.
- Flush: on the next edge out_valid is 0 and nothing is accepted. The register-file write still occurs.
- out_* data fields hold their last value when not loaded. When out_valid is low their values are don't-care, but they must be stable.
- Reset: all registers, all out_* fields, and out_valid go to 0 asynchronously. in_ready is 1 after reset once flush is low.

## Timing
- Latency 1: an instruction accepted at edge N is presented with out_valid high after edge N.
- Throughput: 1 instruction per cycle when out_ready is held high.
- A write-back at edge N is visible to an instruction accepted at edge N through the bypass, not one cycle later.
- Simultaneous consume and accept: new contents load and out_valid stays 1.
- Stall refresh and accept cannot coincide, because in_ready is 0 while stalled.
- Reset asserted mid-stall drops the held instruction. After reset deasserts, no output appears until a new accept.

## Structure
- Package `decode_pkg`:
  - field bit-position localparams, OPCODE_W=6, FUNCT_W=6, SHAMT_W=5, IMM_W=16, ADDR_W=26;
  - a struct typedef for the decoded ID/EX payload.
- Sub-module `reg_file`: parametrised by DATA_W, REG_ADDR_W and ZERO_REG. It has two combinational read ports with bypass, one write port, and async reset.
- Handshake, extension and pipeline register live in `decode_stage`.

## Test plan
- Reset, then write r8=0x0000_00AA via wb. Accept add rd=r9, rs=r8, rt=r8 with reg_dst=1 -> next cycle out_valid=1, out_rs_data=out_rt_data=0xAA, out_dest=9.
- Accept with instr imm=0x8001: zero_ext=0 -> out_imm=0xFFFF_8001; zero_ext=1 -> out_imm=0x0000_8001.
- Same-cycle bypass: wb r3=0x1234 in the same cycle as accepting rs=r3 -> out_rs_data=0x1234. A write to r0 -> out_rs_data=0 for rs=r0.
- Stall: hold out_ready=0 with rs=r5 held, write r5=0x55 -> out_rs_data becomes 0x55, in_ready=0, no new accept. Then release -> consumed.
- Back-to-back: 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles, in order, no bubbles.
- Flush while stalled and in_valid=1 -> next cycle out_valid=0 and incoming instruction dropped. Async reset mid-stall -> out_valid=0 immediately, all registers read 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the MIPS decode stage: instruction field layout,
// the fixed-width part of the ID/EX payload and the field-split helper.
package decode_pkg;

  localparam int INSTR_W     = 32;
  localparam int OPCODE_W    = 6;
  localparam int FUNCT_W     = 6;
  localparam int SHAMT_W     = 5;
  localparam int IMM_W       = 16;
  localparam int ADDR_W      = 26;
  localparam int REG_FIELD_W = 5;

  // Bit positions of each field inside the 32-bit instruction word.
  localparam int OPCODE_LSB  = 26;
  localparam int RS_LSB      = 21;
  localparam int RT_LSB      = 16;
  localparam int RD_LSB      = 11;
  localparam int SHAMT_LSB   = 6;
  localparam int FUNCT_LSB   = 0;
  localparam int IMM_LSB     = 0;
  localparam int ADDR_LSB    = 0;

  // Width-independent part of the ID/EX payload. Register indices are kept
  // at full field width here and narrowed to REG_ADDR_W by the stage.
  typedef struct packed {
    logic [OPCODE_W-1:0]    opcode;
    logic [FUNCT_W-1:0]     funct;
    logic [SHAMT_W-1:0]     shamt;
    logic [ADDR_W-1:0]      addr;
    logic [REG_FIELD_W-1:0] rs;
    logic [REG_FIELD_W-1:0] rt;
    logic [REG_FIELD_W-1:0] dest;
    logic                   reg_write;
  } idex_ctl_t;

  // Split an instruction into its fields and resolve the destination index.
  function automatic idex_ctl_t decode_fields(input logic [INSTR_W-1:0] instr,
                                              input logic               reg_dst,
                                              input logic               reg_write);
    idex_ctl_t c;
    c.opcode    = instr[OPCODE_LSB +: OPCODE_W];
    c.funct     = instr[FUNCT_LSB +: FUNCT_W];
    c.shamt     = instr[SHAMT_LSB +: SHAMT_W];
    c.addr      = instr[ADDR_LSB +: ADDR_W];
    c.rs        = instr[RS_LSB +: REG_FIELD_W];
    c.rt        = instr[RT_LSB +: REG_FIELD_W];
    c.dest      = reg_dst ? instr[RD_LSB +: REG_FIELD_W] : instr[RT_LSB +: REG_FIELD_W];
    c.reg_write = reg_write;
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of the decode stage's fetch-side, execute-side and write-back
// signals. master = surrounding pipeline, slave = decode stage.
interface decode_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  import decode_pkg::*;

  // fetch side
  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_W-1:0]    instr;
  logic                  reg_dst;
  logic                  reg_write;
  logic                  zero_ext;
  logic                  flush;

  // write-back side
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;

  // execute side
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_rs_data;
  logic [DATA_W-1:0]     out_rt_data;
  logic [DATA_W-1:0]     out_imm;
  logic [REG_ADDR_W-1:0] out_rs;
  logic [REG_ADDR_W-1:0] out_rt;
  logic [REG_ADDR_W-1:0] out_dest;
  logic [OPCODE_W-1:0]   out_opcode;
  logic [FUNCT_W-1:0]    out_funct;
  logic [SHAMT_W-1:0]    out_shamt;
  logic [ADDR_W-1:0]     out_addr;
  logic                  out_reg_write;

  modport master (
    output in_valid, instr, reg_dst, reg_write, zero_ext, flush,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_dest,
    input  out_opcode, out_funct, out_shamt, out_addr, out_reg_write
  );

  modport slave (
    input  in_valid, instr, reg_dst, reg_write, zero_ext, flush,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_dest,
    output out_opcode, out_funct, out_shamt, out_addr, out_reg_write
  );

endinterface

// File: rtl/decode_reg_file.sv
// Two-read / one-write register file with write-through bypass on both read
// ports, so an instruction decoded in the same cycle as its producer's
// write-back sees the new value. Register 0 is hardwired to zero when
// ZERO_REG is set.
module reg_file #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;
  logic                        wr_ok;

  // Writes to r0 are dropped when it is the hardwired zero register.
  assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

  // Next-state of the array: only the addressed entry changes.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[waddr] = wdata;
  end

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  // Port A read: pending write wins over stored value.
  always_comb begin
    rdata_a = mem_q[raddr_a];
    if (wr_ok && (waddr == raddr_a))               rdata_a = wdata;
    if ((ZERO_REG != 0) && (raddr_a == '0))        rdata_a = '0;
  end

  // Port B read: same bypass rule as port A.
  always_comb begin
    rdata_b = mem_q[raddr_b];
    if (wr_ok && (waddr == raddr_b))               rdata_b = wdata;
    if ((ZERO_REG != 0) && (raddr_b == '0))        rdata_b = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction decode stage: splits the instruction, reads operands
// through a bypassed register file, extends the immediate and holds the
// result in an ID/EX register behind a valid/ready handshake. While the
// held instruction is stalled, write-backs to its source registers are
// folded into the held operands so execute never sees a stale value.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 1
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  idex_ctl_t             ctl_new, ctl_q, ctl_d;
  logic [DATA_W-1:0]     rs_rd, rt_rd, imm_ext;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rs_idx, rt_idx, held_rs, held_rt;
  logic [IMM_W-1:0]      imm_raw;
  logic                  in_ready, accept, stalled, hit_rs, hit_rt;

  // Field split of the incoming instruction.
  assign ctl_new = decode_fields(bus.instr, bus.reg_dst, bus.reg_write);
  assign rs_idx  = REG_ADDR_W'(ctl_new.rs);
  assign rt_idx  = REG_ADDR_W'(ctl_new.rt);
  assign imm_raw = bus.instr[IMM_LSB +: IMM_W];

  // Immediate extension.
  assign imm_ext = bus.zero_ext ? {{(DATA_W-IMM_W){1'b0}}, imm_raw}
                                : {{(DATA_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};

  reg_file #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_en),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs_idx),
    .rdata_a (rs_rd),
    .raddr_b (rt_idx),
    .rdata_b (rt_rd)
  );

  // Handshake: the slot is free when empty or being drained this cycle.
  assign in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign stalled  = valid_q && !bus.out_ready;

  // Write-back hits against the held source indices (r0 never hits when
  // it is the zero register, so its held zero is never overwritten).
  assign held_rs = REG_ADDR_W'(ctl_q.rs);
  assign held_rt = REG_ADDR_W'(ctl_q.rt);
  assign hit_rs  = bus.wb_en && (bus.wb_addr == held_rs) && ((ZERO_REG == 0) || (held_rs != '0));
  assign hit_rt  = bus.wb_en && (bus.wb_addr == held_rt) && ((ZERO_REG == 0) || (held_rt != '0));

  // ID/EX next state: flush beats accept, accept beats consume; stalled
  // operands are refreshed from the write-back port.
  always_comb begin
    valid_d   = valid_q;
    ctl_d     = ctl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      ctl_d     = ctl_new;
      rs_data_d = rs_rd;
      rt_data_d = rt_rd;
      imm_d     = imm_ext;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
    if (stalled) begin
      if (hit_rs) rs_data_d = bus.wb_data;
      if (hit_rt) rt_data_d = bus.wb_data;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctl_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctl_q     <= ctl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_rs_data   = rs_data_q;
  assign bus.out_rt_data   = rt_data_q;
  assign bus.out_imm       = imm_q;
  assign bus.out_rs        = held_rs;
  assign bus.out_rt        = held_rt;
  assign bus.out_dest      = REG_ADDR_W'(ctl_q.dest);
  assign bus.out_opcode    = ctl_q.opcode;
  assign bus.out_funct     = ctl_q.funct;
  assign bus.out_shamt     = ctl_q.shamt;
  assign bus.out_addr      = ctl_q.addr;
  assign bus.out_reg_write = ctl_q.reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver predicts each accepted
// instruction from a plain register-array model and queues it; a monitor
// pops and compares whenever execute consumes an output.
module tb_decode_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 1;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [25:0] addr;
    logic        rw;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  decode_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] rf[32];
  logic        m_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  // One clock of stimulus plus the reference model's view of that edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic rd_sel, input logic rw,
                     input logic zx, input logic fl, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic ordy);
    exp_t e, h;
    logic rdy, acc;
    @(negedge clk);
    bus.in_valid = v;  bus.instr = ins;  bus.reg_dst = rd_sel; bus.reg_write = rw;
    bus.zero_ext = zx; bus.flush = fl;   bus.wb_en = we;       bus.wb_addr = wa;
    bus.wb_data = wd;  bus.out_ready = ordy;
    #1;
    rdy = !fl && (!m_valid || ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    acc = v && rdy;
    // register file after this edge; an accept on this edge reads it
    if (we && wa != 5'd0) rf[wa] = wd;
    if (fl) begin
      if (m_valid && sb.size() > 0) void'(sb.pop_front());
      m_valid = 1'b0;
    end else begin
      if (m_valid && !ordy && sb.size() > 0) begin
        // a stalled instruction always carries current register contents
        h = sb[0];
        h.rs_data = rf[h.rs];
        h.rt_data = rf[h.rt];
        sb[0] = h;
      end
      if (acc) begin
        e.op      = ins[31:26];
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.dest    = rd_sel ? ins[15:11] : ins[20:16];
        e.sh      = ins[10:6];
        e.fn      = ins[5:0];
        e.addr    = ins[25:0];
        e.imm     = zx ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        e.rs_data = rf[e.rs];
        e.rt_data = rf[e.rt];
        e.rw      = rw;
        sb.push_back(e);
        m_valid = 1'b1;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cyc(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 32'h0, ordy);
  endtask

  // Monitor: every consume is compared against the oldest expectation.
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !bus.flush && bus.out_valid && bus.out_ready) begin
        got = {bus.out_rs_data, bus.out_rt_data, bus.out_imm, bus.out_rs, bus.out_rt,
               bus.out_dest, bus.out_opcode, bus.out_funct, bus.out_shamt, bus.out_addr,
               bus.out_reg_write};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected output %h", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL scoreboard: got %h expected %h at %0t", got, e, $time);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    bus.in_valid = 0; bus.instr = 0; bus.reg_dst = 0; bus.reg_write = 0; bus.zero_ext = 0;
    bus.flush = 0; bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_rs_data", bus.out_rs_data, 32'h0);

    // r8 = 0xAA, then add r9, r8, r8
    cyc(0, 32'h0, 0, 0, 0, 0, 1, 5'd8, 32'h0000_00AA, 1);
    cyc(1, mk_r(8, 8, 9, 'h20), 1, 1, 0, 0, 0, 5'd0, 32'h0, 1);
    @(posedge clk); #1;
    chk("add out_valid", 32'(bus.out_valid), 32'd1);
    chk("add rs_data", bus.out_rs_data, 32'h0000_00AA);
    chk("add rt_data", bus.out_rt_data, 32'h0000_00AA);
    chk("add dest", 32'(bus.out_dest), 32'd9);

    // immediate extension, both modes
    cyc(1, mk_i('h08, 1, 2, 16'h8001), 0, 1, 0, 0, 0, 5'd0, 32'h0, 1);
    @(posedge clk); #1;
    chk("imm sign-ext", bus.out_imm, 32'hFFFF_8001);
    chk("dest rt", 32'(bus.out_dest), 32'd2);
    cyc(1, mk_i('h0d, 1, 2, 16'h8001), 0, 1, 1, 0, 0, 5'd0, 32'h0, 1);
    @(posedge clk); #1;
    chk("imm zero-ext", bus.out_imm, 32'h0000_8001);

    // same-cycle bypass, and r0 stays zero
    cyc(1, mk_r(3, 0, 4, 'h20), 1, 1, 0, 0, 1, 5'd3, 32'h0000_1234, 1);
    @(posedge clk); #1;
    chk("bypass rs_data", bus.out_rs_data, 32'h0000_1234);
    cyc(1, mk_r(0, 3, 4, 'h20), 1, 1, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 1);
    @(posedge clk); #1;
    chk("r0 rs_data", bus.out_rs_data, 32'h0);
    chk("r0 rt_data", bus.out_rt_data, 32'h0000_1234);
    idle(1);

    // stall with refresh of held rs
    cyc(1, mk_r(5, 6, 7, 'h22), 1, 1, 0, 0, 0, 5'd0, 32'h0, 0);
    cyc(1, mk_r(1, 1, 1, 'h20), 1, 1, 0, 0, 1, 5'd5, 32'h0000_0055, 0);
    @(posedge clk); #1;
    chk("stall refresh rs_data", bus.out_rs_data, 32'h0000_0055);
    chk("stall out_valid", 32'(bus.out_valid), 32'd1);
    chk("stall in_ready", 32'(bus.in_ready), 32'd0);
    idle(1);

    // back-to-back, no bubbles
    for (int k = 0; k < 4; k++) cyc(1, mk_r(k + 1, k + 2, k + 10, 'h20), 1, 1, 0, 0, 0, 5'd0, 32'h0, 1);
    idle(1);

    // flush while stalled with a new instruction offered; write-back still lands
    cyc(1, mk_r(2, 3, 4, 'h20), 1, 1, 0, 0, 0, 5'd0, 32'h0, 0);
    cyc(1, mk_r(4, 5, 6, 'h20), 1, 1, 0, 1, 1, 5'd12, 32'h0000_0077, 0);
    @(posedge clk); #1;
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    idle(1);
    cyc(1, mk_r(12, 0, 1, 'h20), 1, 1, 0, 0, 0, 5'd0, 32'h0, 1);
    @(posedge clk); #1;
    chk("wb during flush", bus.out_rs_data, 32'h0000_0077);
    idle(1);

    // randomized traffic on a small register window to force hits
    repeat (1500) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 3) != 0), ins, 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 19) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 9) < 7));
    end
    idle(1);
    idle(1);

    // asynchronous reset in the middle of a stall
    cyc(0, 32'h0, 0, 0, 0, 0, 1, 5'd8, 32'h0000_00AA, 1);
    cyc(1, mk_r(8, 3, 4, 'h20), 1, 1, 0, 0, 0, 5'd0, 32'h0, 1);
    idle(0);
    @(negedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("async reset rs_data", bus.out_rs_data, 32'h0);
    sb.delete();
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1, mk_r(8, 3, 4, 'h20), 1, 1, 0, 0, 0, 5'd0, 32'h0, 1);
    @(posedge clk); #1;
    chk("post-reset r8", bus.out_rs_data, 32'h0);
    chk("post-reset out_valid", 32'(bus.out_valid), 32'd1);
    idle(1);
    idle(1);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
